// File: rtl/range_frame_feeder.sv
// -----------------------------------------------------------------------------
// range_frame_feeder
//
// Upstream stage of the range finder. Collects one complete frame of samples
// over a valid/ready handshake into a local buffer, then replays the frame as
// a gap-free burst on the range finder's data/go/finish interface. go marks
// the first replayed sample and finish marks the last one.
//
// Frames of length 1 are rejected (short_err). Frames longer than DEPTH are
// dropped up to and including their last sample (overflow_err). Both error
// flags are sticky until reset.
//
// Optional feature (macro RANGE_FEEDER_STATS_EN): adds an 8-bit wrapping
// frames_sent counter that increments on every finish strobe.
//
// Parameters:
//   WIDTH  sample width in bits
//   DEPTH  maximum frame length in samples (>= 2)
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high reset
//   in_data       incoming sample
//   in_valid      in_data is valid this cycle
//   in_last       in_data is the final sample of its frame
//   in_ready      feeder can accept a sample this cycle
//   rf_data       sample to the range finder (0 when not streaming)
//   rf_go         first-sample strobe
//   rf_finish     last-sample strobe
//   overflow_err  sticky: a frame exceeded DEPTH samples
//   short_err     sticky: a frame of length 1 was received
//   frames_sent   (RANGE_FEEDER_STATS_EN only) count of finished frames
// -----------------------------------------------------------------------------
module range_frame_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  output logic             overflow_err,
  output logic             short_err
`ifdef RANGE_FEEDER_STATS_EN
  ,
  output logic [7:0]       frames_sent
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_STREAM  = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              short_q, short_d;

  // Frame buffer; contents are never reset.
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic              mem_we;

  logic              accept;
  logic              last_beat;

  // in_ready depends only on state, so acceptance is derived from state
  // directly to keep the handshake free of combinational feedback.
  assign accept    = in_valid && (state_q != S_STREAM);
  assign last_beat = (state_q == S_STREAM) &&
                     (CNT_W'(rd_ptr_q) == (len_q - CNT_W'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FILL;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    short_d    = short_q;
    mem_we     = 1'b0;

    unique case (state_q)
      S_FILL: begin
        rd_ptr_d = '0;
        if (accept) begin
          mem_we = 1'b1;
          if (in_last) begin
            if (wr_cnt_q == '0) begin
              // Single-sample frame: flag it and keep filling from slot 0.
              short_d = 1'b1;
            end else begin
              len_d    = wr_cnt_q + CNT_W'(1);
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
              state_d  = S_STREAM;
            end
          end else if (wr_cnt_q == CNT_W'(DEPTH - 1)) begin
            // Buffer full and the frame keeps going: drop the rest of it.
            overflow_d = 1'b1;
            wr_cnt_d   = '0;
            state_d    = S_DISCARD;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end

      S_STREAM: begin
        if (last_beat) begin
          state_d  = S_FILL;
          rd_ptr_d = '0;
          wr_cnt_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end

      S_DISCARD: begin
        rd_ptr_d = '0;
        if (accept && in_last) begin
          state_d = S_FILL;
        end
      end

      default: begin
        state_d  = S_FILL;
        wr_cnt_d = '0;
        rd_ptr_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffer: synchronous write, registered read.
  // The read address is the pointer value for the next cycle, so rd_data_q
  // already holds mem[rd_ptr_q] whenever the FSM is in STREAM. Frames are at
  // least two samples long, so slot 0 is always written before the cycle that
  // enters STREAM, and no write ever happens during STREAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_cnt_q[PTR_W-1:0]] <= in_data;
    end
    rd_data_q <= mem[rd_ptr_d];
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b1;
    rf_data   = '0;
    rf_go     = 1'b0;
    rf_finish = 1'b0;
    if (state_q == S_STREAM) begin
      in_ready  = 1'b0;
      rf_data   = rd_data_q;
      rf_go     = (rd_ptr_q == '0);
      rf_finish = last_beat;
    end
  end

  assign overflow_err = overflow_q;
  assign short_err    = short_q;

`ifdef RANGE_FEEDER_STATS_EN
  logic [7:0] frames_sent_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      frames_sent_q <= '0;
    end else if (last_beat) begin
      frames_sent_q <= frames_sent_q + 8'd1;
    end
  end

  assign frames_sent = frames_sent_q;
`endif

endmodule
